morph_stream_filter: RTL and testbench
======================================

// Module: morph_stream_filter
// PURPOSE
//  Streaming grey-scale erosion/dilation over a KxK square window. Next generation of the fixed 5x5 combinational erode:
//  window size, pixel width and image size are parameters, and erode/dilate is selected per frame.
//  Builds its own window from a raster pixel stream with internal line buffers, valid/ready on both sides.
//  Sits between the pixel source and the multiscale combiner; one instance per scale.
// PARAMETERS
//  DATA_W  8    pixel width, bits
//  K       5    window side; odd, 3..7; R=(K-1)/2
//  IMG_W   64   pixels per line, >= K
//  IMG_H   64   lines per frame, >= K
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       async active-low reset
//  mode       in   1       0=erode (min), 1=dilate (max); sampled on accepted in_sof pixel
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       block accepts input pixel this cycle
//  in_data    in   DATA_W  input pixel, raster order
//  in_sof     in   1       marks pixel (0,0) of a frame
//  out_valid  out  1       output pixel valid
//  out_ready  in   1       sink accepts output pixel
//  out_data   out  DATA_W  filtered pixel, raster order
//  out_sof    out  1       with out_valid: output pixel (0,0)
//  out_eol    out  1       with out_valid: last pixel of an output line
//  busy       out  1       frame in progress (first pixel accepted .. last pixel output)
//  sof_err    out  1       sticky: in_sof on a non-(0,0) pixel or missing on (0,0)
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; counters (0,0); line buffers need no clear; mode latch=erode.
//  Stall: en = !(out_valid && !out_ready). en=0 freezes every register (counters, buffers, pipe).
//  Scan: virtual grid (IMG_H+R) x (IMG_W+R), positions (vr,vc), raster order, one position per en cycle.
//    vr<IMG_H && vc<IMG_W: real position; in_ready=en; advances only on in_valid&&in_ready.
//    otherwise: pad position; in_ready=0; advances every en cycle without input (self-flush).
//  After (IMG_H+R-1, IMG_W+R-1): counters to (0,0), idle, in_ready=en.
//  Window at (vr,vc) is centred on image pixel (vr-R, vc-R); any tap outside 0..IMG_H-1 / 0..IMG_W-1
//    reads the neutral value: all-ones for erode, 0 for dilate (i.e. out-of-image taps ignored).
//  Output produced only for vr>=R && vc>=R -> exactly IMG_W*IMG_H outputs per frame, raster order.
//  Pipeline: stage 1 per-row K-way min/max (registered), stage 2 K-way reduce into out_data (registered).
//    Latency = 2 en cycles from scan position to out_valid.
//  out_sof = output pixel (0,0); out_eol = column IMG_W-1. Both 0 when out_valid=0.
//  busy rises with accepted in_sof pixel, falls the cycle the last output is accepted.
//  Mode: held per frame in latch; changing mode mid-frame has no effect until next frame.
//  Next frame's (0,0) is accepted only once the scan has wrapped; it may overlap the old frame's output drain.
//  sof_err: set on accepted pixel where in_sof != (vr==0&&vc==0); counters do not resync; cleared by reset only.
//  Reset mid-frame: immediate abort, outputs to reset values, partial frame discarded.
//  Widths: col counter clog2(IMG_W+R), row counter clog2(IMG_H+R); compare is unsigned DATA_W.
// STRUCTURE
//  morph_pkg: MODE_ERODE/MODE_DILATE constants, function neutral(mode) and minmax(a,b,mode).
//  Sub-module morph_line_buffer: K-1 rows x IMG_W x DATA_W, one read+write per en cycle, delay-line
//    cascade (row i output feeds row i+1 input); window shift register (K x K) lives in top level.
// TESTING
//  K=3,8x6 image all 100, pixel (2,3)=10, erode -> 3x3 block rows1..3 cols2..4 =10, rest 100; 48 outputs.
//  Same frame, pixel (2,3)=200, rest 0, dilate -> rows1..3 cols2..4 =200, rest 0.
//  Border: K=5, constant 50, both modes -> all 48 outputs 50 (neutral padding, no edge artefacts).
//  Backpressure: random in_valid and out_ready 50% -> output sequence identical to unstalled run;
//    out_data stable while out_valid&&!out_ready.
//  Back-to-back frames: erode then dilate, mode flipped mid-frame 1 -> frame 1 fully erode, frame 2 dilate;
//    out_sof/out_eol counts 1 and IMG_H per frame.
//  rst_n low mid-frame -> outputs reset at once; next full frame correct; sof_err set if in_sof on (0,1).

Source files
------------

// File: rtl/morph_pkg.sv
// Shared constants, sideband tag and min/max helpers for the streaming morphology filter.
package morph_pkg;
    localparam int   PIX_MAX     = 32;
    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } morph_tag_t;

    // Value that can never win the reduction for the given mode.
    function automatic logic [PIX_MAX-1:0] neutral(input logic mode);
        return (mode == MODE_DILATE) ? {PIX_MAX{1'b0}} : {PIX_MAX{1'b1}};
    endfunction

    function automatic logic [PIX_MAX-1:0] minmax(input logic [PIX_MAX-1:0] a,
                                                 input logic [PIX_MAX-1:0] b,
                                                 input logic mode);
        if (mode == MODE_DILATE)
            return (a > b) ? a : b;
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/morph_line_buffer.sv
// K-1 line delay cascade; row i holds the pixels of line vr-1-i at the same column.
module morph_line_buffer #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                addr,
    input  logic [DATA_W-1:0]            din,
    output logic [ROWS-1:0][DATA_W-1:0]  dout
);
    logic [DATA_W-1:0] mem [ROWS][DEPTH];

    always_comb begin
        for (int i = 0; i < ROWS; i++) dout[i] = mem[i][addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][addr] <= din;
            for (int i = 1; i < ROWS; i++) mem[i][addr] <= mem[i-1][addr];
        end
    end
endmodule

// File: rtl/morph_stream_filter.sv
// Streaming KxK grey-scale erode/dilate with self-flushing raster scan and 2-stage reduce pipe.
module morph_stream_filter
    import morph_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic              sof_err
);
    localparam int R  = (K - 1) / 2;
    localparam int CW = $clog2(IMG_W + R);
    localparam int RW = $clog2(IMG_H + R);
    localparam int AW = $clog2(IMG_W);

    logic [RW-1:0] vr;
    logic [CW-1:0] vc;
    int            vri, vci;
    logic          en, real_pos, origin, step, acc, lb_we, mode_q, mode_cur, m1, vld_s0;
    logic [2:1]    vld_pipe;
    logic [DATA_W-1:0] neut, red;
    logic [K-2:0][DATA_W-1:0]          lb_rd;
    logic [K-1:0][DATA_W-1:0]          taps, col_cur, row_d, row_q;
    logic [K-2:0][K-1:0][DATA_W-1:0]   win;
    morph_tag_t    tag_d, tag1, tag2;

    assign vri      = int'(vr);
    assign vci      = int'(vc);
    assign en       = !(vld_pipe[2] && !out_ready);
    assign real_pos = (vri < IMG_H) && (vci < IMG_W);
    assign origin   = (vr == '0) && (vc == '0);
    assign in_ready = real_pos && en;
    assign acc      = in_valid && in_ready;
    // Pad positions advance on their own so the frame tail flushes without extra input.
    assign step     = en && (real_pos ? in_valid : 1'b1);
    assign lb_we    = step && (vci < IMG_W);
    assign mode_cur = origin ? mode : mode_q;
    assign neut     = DATA_W'(neutral(mode_cur));
    assign taps     = {lb_rd, in_data};

    assign vld_s0   = step && (vri >= R) && (vci >= R);
    assign tag_d.sof  = vld_s0 && (vri == R) && (vci == R);
    assign tag_d.eol  = vld_s0 && (vci == IMG_W + R - 1);
    assign tag_d.last = tag_d.eol && (vri == IMG_H + R - 1);

    assign out_valid = vld_pipe[2];
    assign out_sof   = tag2.sof;
    assign out_eol   = tag2.eol;

    morph_line_buffer #(.DATA_W(DATA_W), .ROWS(K-1), .DEPTH(IMG_W), .AW(AW)) u_lb (
        .clk  (clk),
        .we   (lb_we),
        .addr (vc[AW-1:0]),
        .din  (in_data),
        .dout (lb_rd)
    );

    // Taps above the frame hold stale lines from the previous frame, so mask by row as well.
    always_comb begin
        for (int j = 0; j < K; j++)
            col_cur[j] = ((vci < IMG_W) && (vri >= j) && (vri - j < IMG_H)) ? taps[j] : neut;
        for (int r = 0; r < K; r++) begin
            row_d[r] = col_cur[r];
            for (int c = 0; c < K - 1; c++)
                row_d[r] = DATA_W'(minmax(PIX_MAX'(row_d[r]), PIX_MAX'(win[c][r]), mode_cur));
        end
        red = row_q[0];
        for (int r = 1; r < K; r++)
            red = DATA_W'(minmax(PIX_MAX'(red), PIX_MAX'(row_q[r]), m1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vr       <= '0;
            vc       <= '0;
            mode_q   <= MODE_ERODE;
            win      <= '0;
            row_q    <= '0;
            m1       <= MODE_ERODE;
            out_data <= '0;
            vld_pipe <= '0;
            tag1     <= '0;
            tag2     <= '0;
            busy     <= 1'b0;
            sof_err  <= 1'b0;
        end else begin
            if (step) begin
                if (origin) mode_q <= mode;
                if (vci == IMG_W + R - 1) begin
                    vc <= '0;
                    vr <= (vri == IMG_H + R - 1) ? '0 : vr + RW'(1);
                end else begin
                    vc <= vc + CW'(1);
                end
                win[0] <= col_cur;
                for (int c = 1; c < K - 1; c++) win[c] <= win[c-1];
            end
            if (en) begin
                vld_pipe <= {vld_pipe[1], vld_s0};
                tag1     <= tag_d;
                tag2     <= vld_pipe[1] ? tag1 : '0;
                row_q    <= row_d;
                m1       <= mode_cur;
                out_data <= red;
            end
            if (acc && origin)
                busy <= 1'b1;
            else if (vld_pipe[2] && out_ready && tag2.last)
                busy <= 1'b0;
            if (acc && (in_sof != origin))
                sof_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_morph_stream_filter.sv
// Bench: K=3 (idx 0) and K=5 (idx 1) filters on an 8x6 image against a window-scan reference.
module tb_morph_stream_filter;
    localparam int W = 8, H = 6, NPIX = W * H;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode, in_valid, in_ready, in_sof, out_valid, out_ready, out_sof, out_eol, busy, sof_err;
    logic [1:0][7:0] in_data, out_data;

    int n_tests = 0, n_fail = 0;
    int stab_viol;
    logic [7:0] img [NPIX];
    logic [7:0] got_d [$];
    bit got_sof [$];
    bit got_eol [$];

    always #5 clk = ~clk;

    morph_stream_filter #(.DATA_W(8), .K(3), .IMG_W(W), .IMG_H(H)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_sof(in_sof[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]), .busy(busy[0]),
        .sof_err(sof_err[0]));

    morph_stream_filter #(.DATA_W(8), .K(5), .IMG_W(W), .IMG_H(H)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_sof(in_sof[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]), .busy(busy[1]),
        .sof_err(sof_err[1]));

    // Reference: min/max over the in-image part of the KxK neighbourhood.
    function automatic logic [7:0] ref_px(input int k, input bit dil, input int r, input int c);
        int rr, y, x;
        logic [7:0] a;
        rr = (k - 1) / 2;
        a = dil ? 8'h00 : 8'hFF;
        for (int dr = -rr; dr <= rr; dr++) begin
            for (int dc = -rr; dc <= rr; dc++) begin
                y = r + dr;
                x = c + dc;
                if (y >= 0 && y < H && x >= 0 && x < W) begin
                    if (dil && img[y*W+x] > a) a = img[y*W+x];
                    if (!dil && img[y*W+x] < a) a = img[y*W+x];
                end
            end
        end
        return a;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endtask

    // Streams img into one DUT and collects its outputs; stop_after>0 abandons the frame early.
    task automatic run_frame(input int idx, input bit dil, input bit flip, input bit sof01,
                             input int vp, input int rp, input int stop_after);
        int p, cyc;
        bit held;
        logic [7:0] hv;
        p = 0; cyc = 0; held = 0; hv = '0; stab_viol = 0;
        got_d.delete(); got_sof.delete(); got_eol.delete();
        while (got_d.size() < NPIX && cyc < 4000 && !(stop_after > 0 && p >= stop_after)) begin
            @(negedge clk);
            cyc++;
            out_ready[idx] = ($urandom_range(99) < rp);
            if (p < NPIX) begin
                in_valid[idx] = ($urandom_range(99) < vp);
                in_data[idx]  = img[p];
                in_sof[idx]   = (p == 0) || (sof01 && p == 1);
                mode[idx]     = (flip && p >= NPIX / 2) ? !dil : dil;
            end else begin
                in_valid[idx] = 1'b0;
                in_sof[idx]   = 1'b0;
            end
            #1;
            if (held && out_data[idx] !== hv) stab_viol++;
            if (in_valid[idx] && in_ready[idx]) p++;
            if (out_valid[idx] && out_ready[idx]) begin
                got_d.push_back(out_data[idx]);
                got_sof.push_back(out_sof[idx]);
                got_eol.push_back(out_eol[idx]);
            end
            held = out_valid[idx] && !out_ready[idx];
            hv   = out_data[idx];
        end
        @(negedge clk);
        in_valid[idx] = 1'b0; in_sof[idx] = 1'b0; out_ready[idx] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready[0]); end
        n_tests++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid[0]); end
        n_tests++; if (out_data[0] !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data[0]); end
        n_tests++; if (out_sof[0] !== 1'b0 || out_eol[0] !== 1'b0) begin n_fail++; $display("FAIL reset_sof_eol got %b%b want 00", out_sof[0], out_eol[0]); end
        n_tests++; if (busy[0] !== 1'b0 || sof_err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err got %b%b want 00", busy[0], sof_err[0]); end
        n_tests++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_k5 got %b want 1", in_ready[1]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_point_erode();
        fill_const(8'd100);
        img[2*W+3] = 8'd10;
        run_frame(0, 1'b0, 1'b0, 1'b0, 100, 100, 0);
        n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL erode_count got %0d want %0d", got_d.size(), NPIX); end
        for (int i = 0; i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== ((i/W >= 1 && i/W <= 3 && i%W >= 2 && i%W <= 4) ? 8'd10 : 8'd100)) begin
                n_fail++; $display("FAIL erode_px(%0d,%0d) got %0d", i/W, i%W, got_d[i]);
            end
        end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL erode_busy_end got %b want 0", busy[0]); end
    endtask

    task automatic test_point_dilate();
        fill_const(8'd0);
        img[2*W+3] = 8'd200;
        run_frame(0, 1'b1, 1'b0, 1'b0, 100, 100, 0);
        n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL dilate_count got %0d want %0d", got_d.size(), NPIX); end
        for (int i = 0; i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== ((i/W >= 1 && i/W <= 3 && i%W >= 2 && i%W <= 4) ? 8'd200 : 8'd0)) begin
                n_fail++; $display("FAIL dilate_px(%0d,%0d) got %0d", i/W, i%W, got_d[i]);
            end
        end
    endtask

    task automatic test_border();
        fill_const(8'd50);
        for (int m = 0; m < 2; m++) begin
            run_frame(1, m[0], 1'b0, 1'b0, 100, 100, 0);
            n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL border_count m%0d got %0d want %0d", m, got_d.size(), NPIX); end
            for (int i = 0; i < got_d.size(); i++) begin
                n_tests++;
                if (got_d[i] !== 8'd50) begin n_fail++; $display("FAIL border_px m%0d (%0d,%0d) got %0d want 50", m, i/W, i%W, got_d[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            run_frame(t % 2, t[1], 1'b0, 1'b0, 50, 50, 0);
            n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL bp_count t%0d got %0d want %0d", t, got_d.size(), NPIX); end
            for (int i = 0; i < got_d.size(); i++) begin
                n_tests++;
                if (got_d[i] !== ref_px((t % 2) ? 5 : 3, t[1], i/W, i%W)) begin
                    n_fail++; $display("FAIL bp_px t%0d (%0d,%0d) got %0d want %0d", t, i/W, i%W, got_d[i], ref_px((t % 2) ? 5 : 3, t[1], i/W, i%W));
                end
            end
            n_tests++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stable t%0d got %0d changes want 0", t, stab_viol); end
        end
    endtask

    task automatic test_back_to_back();
        int ns, ne;
        for (int f = 0; f < 2; f++) begin
            fill_rand();
            run_frame(0, f[0], (f == 0), 1'b0, 80, 80, 0);
            ns = 0; ne = 0;
            n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL b2b_count f%0d got %0d want %0d", f, got_d.size(), NPIX); end
            for (int i = 0; i < got_d.size(); i++) begin
                ns += int'(got_sof[i]);
                ne += int'(got_eol[i]);
                n_tests++;
                if (got_d[i] !== ref_px(3, f[0], i/W, i%W) || got_sof[i] !== (i == 0) || got_eol[i] !== (i%W == W-1)) begin
                    n_fail++; $display("FAIL b2b_px f%0d (%0d,%0d) got %0d/%b%b want %0d", f, i/W, i%W, got_d[i], got_sof[i], got_eol[i], ref_px(3, f[0], i/W, i%W));
                end
            end
            n_tests++; if (ns != 1 || ne != H) begin n_fail++; $display("FAIL b2b_marks f%0d got sof=%0d eol=%0d want 1/%0d", f, ns, ne, H); end
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        run_frame(0, 1'b1, 1'b0, 1'b0, 100, 100, 20);
        n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy[0]); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset got v=%b b=%b r=%b want 0 0 1", out_valid[0], busy[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand();
        for (int f = 0; f < 2; f++) begin
            run_frame(0, 1'b0, 1'b0, f[0], 70, 70, 0);
            n_tests++; if (got_d.size() != NPIX) begin n_fail++; $display("FAIL post_count f%0d got %0d want %0d", f, got_d.size(), NPIX); end
            for (int i = 0; i < got_d.size(); i++) begin
                n_tests++;
                if (got_d[i] !== ref_px(3, 1'b0, i/W, i%W)) begin
                    n_fail++; $display("FAIL post_px f%0d (%0d,%0d) got %0d want %0d", f, i/W, i%W, got_d[i], ref_px(3, 1'b0, i/W, i%W));
                end
            end
            n_tests++; if (sof_err[0] !== f[0]) begin n_fail++; $display("FAIL sof_err f%0d got %b want %b", f, sof_err[0], f[0]); end
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (sof_err[0] !== 1'b0) begin n_fail++; $display("FAIL sof_err_clear got %b want 0", sof_err[0]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mode = '0; in_valid = '0; in_sof = '0; in_data = '0; out_ready = 2'b11;
        test_reset();
        test_point_erode();
        test_point_dilate();
        test_border();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
